cmp_iter: RTL and testbench

CMP_ITER -- requirements
Module: cmp_iter

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp_chunk.sv | 17 +
 rtl/cmp_iter.sv | 79 +++++++
 tb/tb_cmp_iter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: op codes, FSM state encoding and result helpers shared by cmp_iter.
package cmp_pkg;
  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LEZ = 3'd2;
  localparam logic [2:0] OP_GEZ = 3'd3;
  localparam logic [2:0] OP_GTZ = 3'd4;
  localparam logic [2:0] OP_LTZ = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_LTU = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic logic op_zero(input logic [2:0] op);
    return op inside {[OP_LEZ:OP_LTZ]};
  endfunction
  function automatic logic op_taken(input logic [2:0] op, input logic eq, input logic lt);
    return op == OP_EQ  ? eq :
           op == OP_NE  ? !eq :
           op == OP_LEZ ? (lt | eq) :
           op == OP_GEZ ? !lt :
           op == OP_GTZ ? (!lt & !eq) : lt;
  endfunction
endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational CHUNK-bit unsigned compare, optionally flipping the MSB for signed order.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_sgn,
  output logic             o_eq,
  output logic             o_lt
);
  logic [CHUNK-1:0] w_flip, w_a, w_b;
  assign w_flip = CHUNK'(i_sgn) << (CHUNK - 1);
  assign w_a = i_a ^ w_flip;
  assign w_b = i_b ^ w_flip;
  assign o_eq = w_a == w_b;
  assign o_lt = w_a < w_b;
endmodule

// File: rtl/cmp_iter.sv
// cmp_iter: iterative chunk-serial comparator, MS chunk first; op 7 (LTU) enabled by CMP_UNSIGNED_EN.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_eq,
  output logic             out_lt
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0] r_op;
  logic [CW-1:0] r_cnt;
  logic r_eq, r_lt;
  logic w_first, w_sgn, w_keep, w_ceq, w_clt, w_lt;
  assign w_first = r_cnt == '0;
  assign w_sgn = w_first & (r_op != OP_LTU);
  assign w_keep = w_first | r_eq;
  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (r_a[WIDTH-1 -: CHUNK]),
    .i_b  (r_b[WIDTH-1 -: CHUNK]),
    .i_sgn(w_sgn),
    .o_eq (w_ceq),
    .o_lt (w_clt)
  );
`ifdef CMP_UNSIGNED_EN
  assign w_lt = r_lt;
`else
  assign w_lt = r_lt & (r_op != OP_LTU);
`endif
  assign in_ready = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign out_eq = out_valid & r_eq;
  assign out_lt = out_valid & w_lt;
  assign out_taken = out_valid & op_taken(r_op, r_eq, w_lt);
  // Operands shift left each RUN cycle so the chunk under test is always at the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a <= '0;
      r_b <= '0;
      r_op <= OP_EQ;
      r_cnt <= '0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE && in_valid) begin
      r_state <= S_RUN;
      r_a <= in_a;
      r_b <= op_zero(in_op) ? '0 : in_b;
      r_op <= in_op;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a <= r_a << CHUNK;
      r_b <= r_b << CHUNK;
      r_cnt <= r_cnt + 1'b1;
      r_eq <= w_keep & w_ceq;
      r_lt <= w_keep ? w_clt : r_lt;
      if (r_cnt == CW'(NCH - 1)) r_state <= S_DONE;
    end else if (r_state == S_DONE && out_ready) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_cmp_iter.sv
// tb_cmp_iter: randomized scoreboard bench for cmp_iter against an arithmetic reference model.
module tb_cmp_iter;
  logic clk = 0, reset = 0, in_valid = 0, in_ready, flush = 0;
  logic out_valid, out_ready = 1, out_taken, out_eq, out_lt;
  logic [31:0] in_a = 0, in_b = 0;
  logic [2:0] in_op = 0;
  int n_chk = 0, n_fail = 0;
  logic [2:0] exp_q[$];

  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_eq(out_eq), .out_lt(out_lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] bb;
    logic eq, lt, t;
    bb = (op >= 2 && op <= 5) ? 32'd0 : b;
    eq = a == bb;
    if (op == 7)
`ifdef CMP_UNSIGNED_EN
      lt = a < bb;
`else
      lt = 1'b0;
`endif
    else
      lt = $signed(a) < $signed(bb);
    case (op)
      0: t = eq;
      1: t = !eq;
      2: t = $signed(a) <= 0;
      3: t = $signed(a) >= 0;
      4: t = $signed(a) > 0;
      5: t = $signed(a) < 0;
      default: t = lt;
    endcase
    return {t, eq, lt};
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %b expected none", {out_taken, out_eq, out_lt});
      end else chk("result", {29'd0, out_taken, out_eq, out_lt}, {29'd0, exp_q.pop_front()});
    end else if (!out_valid) chk("idle_zero", {29'd0, out_taken, out_eq, out_lt}, 32'd0);
  end

  // abort: 0 none, 1 flush two cycles after accept, 2 reset mid-RUN, 3 reset while result held
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int stall, input int abort);
    int n;
    logic [2:0] snap;
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_op = op; in_valid = 1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 0;
    exp_q.push_back(model(a, b, op));
    in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(0, 7));
    if (abort == 1) begin
      @(posedge clk); #1;
      flush = 1; in_valid = 1; in_op = 0;
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      void'(exp_q.pop_back());
      chk("flush_ready", in_ready, 1);
      chk("flush_valid", out_valid, 0);
      repeat (6) @(posedge clk);
      #1 chk("flush_no_result", out_valid, 0);
      return;
    end
    if (abort == 2) begin
      @(posedge clk); #3;
      chk("run_busy", in_ready, 0);
      reset = 0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      void'(exp_q.pop_back());
      @(posedge clk); #1 reset = 1;
      repeat (6) @(posedge clk);
      #1 chk("rst_no_result", out_valid, 0);
      chk("rst_ready_after", in_ready, 1);
      return;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
    if (!out_valid) begin
      void'(exp_q.pop_back());
      out_ready = 1;
      return;
    end
    snap = {out_taken, out_eq, out_lt};
    if (abort == 3) begin
      #2 reset = 0;
      #1;
      chk("rst_done_valid", out_valid, 0);
      chk("rst_done_out", {29'd0, out_taken, out_eq, out_lt}, 32'd0);
      chk("rst_done_ready", in_ready, 1);
      void'(exp_q.pop_back());
      @(posedge clk); #1 reset = 1;
      out_ready = 1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_hold", {29'd0, out_taken, out_eq, out_lt}, {29'd0, snap});
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_hs_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
  endtask

  initial begin
    #3;
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_out", {29'd0, out_taken, out_eq, out_lt}, 32'd0);
    @(posedge clk); #1 reset = 1;
    do_op(32'h12345678, 32'h12345678, 3'd0, 0, 0);
    do_op(32'hFFFFFFFF, 32'h00000001, 3'd6, 0, 0);
    do_op(32'hFFFFFFFF, 32'h00000001, 3'd7, 0, 0);
    do_op(32'h00000000, 32'hDEADBEEF, 3'd4, 0, 0);
    do_op(32'h80000000, 32'hDEADBEEF, 3'd2, 0, 0);
    do_op(32'h7FFFFFFF, 32'hDEADBEEF, 3'd3, 0, 0);
    do_op(32'h00000000, 32'hDEADBEEF, 3'd5, 0, 0);
    do_op(32'h00000001, 32'h80000000, 3'd7, 0, 0);
    do_op(32'h12345678, 32'h12345678, 3'd0, 0, 1);
    do_op(32'hCAFEF00D, 32'hCAFEF00D, 3'd0, 0, 0);
    do_op(32'h11223344, 32'h11223345, 3'd6, 5, 0);
    do_op(32'h55555555, 32'hAAAAAAAA, 3'd6, 0, 2);
    do_op(32'h00000000, 32'h00000001, 3'd1, 0, 0);
    do_op(32'h12345678, 32'h12345678, 3'd0, 2, 3);
    do_op(32'h80000000, 32'h7FFFFFFF, 3'd6, 0, 0);
    repeat (50) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'd1 << $urandom_range(0, 31));
        2: b = a ^ 32'($urandom_range(0, 255));
        default: b = $urandom;
      endcase
      do_op(a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 2), 0);
    end
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
